// File: rtl/controller_regs.sv
// CPU-visible controller registers: latest button state, sticky press edges and poll status.
// Optional CONTROLLER_REGS_RELEASED_EN adds sticky release-edge registers at address 5+k.
module controller_regs #(
  parameter int unsigned NUM_CONTROLLERS = 2
) (
  input  logic                           clk_1,
  input  logic                           rst_b,
  input  logic [8*NUM_CONTROLLERS-1:0]   buttons_in,
  input  logic                           buttons_valid,
  input  logic [2:0]                     cpu_addr,
  input  logic                           cpu_read_en,
  output logic [7:0]                     cpu_data_out
);

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned STATUS_ADDR   = 4;
  localparam int unsigned RELEASED_BASE = 5;

  logic [NUM_CONTROLLERS-1:0][BYTE_W-1:0] btn_c;
  logic [NUM_CONTROLLERS-1:0][BYTE_W-1:0] state_q;
  logic [NUM_CONTROLLERS-1:0][BYTE_W-1:0] prev_q;
  logic [NUM_CONTROLLERS-1:0][BYTE_W-1:0] pressed_q;
  logic                                   fresh_q;
  logic                                   overrun_q;
  logic [NUM_CONTROLLERS-1:0]             clr_pressed_c;
  logic                                   clr_status_c;
  logic [BYTE_W-1:0]                      rd_data_c;
`ifdef CONTROLLER_REGS_RELEASED_EN
  logic [NUM_CONTROLLERS-1:0][BYTE_W-1:0] released_q;
  logic [NUM_CONTROLLERS-1:0]             clr_released_c;
`endif

  assign btn_c = buttons_in;

  // PREV is architectural history with no read port; keep it visible to lint as intentionally unread
  logic unused_prev;
  assign unused_prev = ^prev_q;

  // Read mux and clear-on-read decode; unmapped addresses fall through to zero
  always_comb begin
    rd_data_c     = '0;
    clr_pressed_c = '0;
    clr_status_c  = 1'b0;
`ifdef CONTROLLER_REGS_RELEASED_EN
    clr_released_c = '0;
`endif
    for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
      if (cpu_addr == ADDR_W'(k)) begin
        rd_data_c = state_q[k];
      end
      if (cpu_addr == ADDR_W'(NUM_CONTROLLERS + k)) begin
        rd_data_c        = pressed_q[k];
        clr_pressed_c[k] = cpu_read_en;
      end
`ifdef CONTROLLER_REGS_RELEASED_EN
      if (cpu_addr == ADDR_W'(RELEASED_BASE + k)) begin
        rd_data_c         = released_q[k];
        clr_released_c[k] = cpu_read_en;
      end
`endif
    end
    if (cpu_addr == ADDR_W'(STATUS_ADDR)) begin
      rd_data_c    = {6'b0, overrun_q, fresh_q};
      clr_status_c = cpu_read_en;
    end
  end

  // Captures and clears share a cycle: the clear drops old bits, newly arriving bits still set
  always_ff @(posedge clk_1 or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= '0;
      prev_q       <= '0;
      pressed_q    <= '0;
      fresh_q      <= 1'b0;
      overrun_q    <= 1'b0;
      cpu_data_out <= '0;
`ifdef CONTROLLER_REGS_RELEASED_EN
      released_q   <= '0;
`endif
    end else begin
      if (cpu_read_en) begin
        cpu_data_out <= rd_data_c;
      end
      for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
        pressed_q[k] <= (pressed_q[k] & ~{BYTE_W{clr_pressed_c[k]}}) |
                        (btn_c[k] & ~state_q[k] & {BYTE_W{buttons_valid}});
`ifdef CONTROLLER_REGS_RELEASED_EN
        released_q[k] <= (released_q[k] & ~{BYTE_W{clr_released_c[k]}}) |
                         (~btn_c[k] & state_q[k] & {BYTE_W{buttons_valid}});
`endif
        if (buttons_valid) begin
          prev_q[k]  <= state_q[k];
          state_q[k] <= btn_c[k];
        end
      end
      fresh_q   <= buttons_valid | (fresh_q & ~clr_status_c);
      overrun_q <= (buttons_valid & fresh_q & ~clr_status_c) | (overrun_q & ~clr_status_c);
    end
  end

endmodule

// File: tb/tb_controller_regs.sv
// Scoreboard bench for controller_regs (NUM_CONTROLLERS=2): directed vectors then model-checked random traffic.
module tb_controller_regs;

  logic        clk_1;
  logic        rst_b;
  logic [15:0] buttons_in;
  logic        buttons_valid;
  logic [2:0]  cpu_addr;
  logic        cpu_read_en;
  logic [7:0]  cpu_data_out;

`ifdef CONTROLLER_REGS_RELEASED_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic [7:0] m_state[2];
  logic [7:0] m_pressed[2];
  logic [7:0] m_released[2];
  logic       m_fresh;
  logic       m_over;

  controller_regs #(.NUM_CONTROLLERS(2)) dut (
    .clk_1        (clk_1),
    .rst_b        (rst_b),
    .buttons_in   (buttons_in),
    .buttons_valid(buttons_valid),
    .cpu_addr     (cpu_addr),
    .cpu_read_en  (cpu_read_en),
    .cpu_data_out (cpu_data_out)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; a read pushes its expectation, which is popped once the data is out
  task automatic cyc(input logic v, input logic [15:0] b, input logic rd, input logic [2:0] a,
                     input logic [7:0] exp, input string tag);
    logic [7:0] e;
    string      t;
    @(negedge clk_1);
    buttons_valid = v;
    buttons_in    = b;
    cpu_read_en   = rd;
    cpu_addr      = a;
    if (rd) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk_1);
    #1;
    buttons_valid = 1'b0;
    cpu_read_en   = 1'b0;
    if (rd && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, cpu_data_out, e);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_1);
    rst_b = 1'b0;
    buttons_valid = 1'b0;
    cpu_read_en   = 1'b0;
    buttons_in    = '0;
    cpu_addr      = '0;
    repeat (2) @(posedge clk_1);
    #1;
    check("reset_out", cpu_data_out, 8'h00);
    @(negedge clk_1);
    rst_b = 1'b1;
  endtask

  function automatic logic [7:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_state[0];
      3'd1: return m_state[1];
      3'd2: return m_pressed[0];
      3'd3: return m_pressed[1];
      3'd4: return {6'b0, m_over, m_fresh};
      3'd5: return REL ? m_released[0] : 8'h00;
      3'd6: return REL ? m_released[1] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input logic v, input logic [15:0] b, input logic rd, input logic [2:0] a);
    logic [7:0] nb;
    logic       clr_s;
    for (int k = 0; k < 2; k++) begin
      nb = b[8*k +: 8];
      if (rd && a == 3'(2 + k)) m_pressed[k] = 8'h00;
      if (rd && a == 3'(5 + k)) m_released[k] = 8'h00;
      if (v) begin
        m_pressed[k]  = m_pressed[k] | (nb & ~m_state[k]);
        m_released[k] = m_released[k] | (~nb & m_state[k]);
        m_state[k]    = nb;
      end
    end
    clr_s = rd && a == 3'd4;
    if (clr_s) begin
      m_fresh = 1'b0;
      m_over  = 1'b0;
    end
    if (v) begin
      if (m_fresh) m_over = 1'b1;
      m_fresh = 1'b1;
    end
  endtask

  initial begin
    logic        v, rd;
    logic [15:0] b;
    logic [2:0]  a;
    rst_b = 1'b1;
    buttons_valid = 1'b0;
    cpu_read_en   = 1'b0;
    buttons_in    = '0;
    cpu_addr      = '0;
    apply_reset();

    // all mapped registers clear after reset
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1, 3'(i), 8'h00, "reset_read");

    // basic capture and press edges, PRESSED clears on read
    cyc(1'b1, 16'h8001, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 8'h01, "state0");
    cyc(1'b0, 16'h0, 1'b1, 3'd1, 8'h80, "state1");
    cyc(1'b0, 16'h0, 1'b1, 3'd2, 8'h01, "pressed0");
    cyc(1'b0, 16'h0, 1'b1, 3'd3, 8'h80, "pressed1");
    cyc(1'b0, 16'h0, 1'b1, 3'd2, 8'h00, "pressed0_cleared");

    // status fresh, then overrun after two polls, cleared by read
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h01, "status_fresh");
    cyc(1'b1, 16'h8001, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b1, 16'h8001, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h03, "status_overrun");
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h00, "status_cleared");

    // read data holds across idle cycles
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 8'h01, "state0_again");
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 8'h00, "");
    check("hold", cpu_data_out, 8'h01);

    // same-cycle capture and clearing read: old value returned, only new edges remain
    cyc(1'b1, 16'h8000, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b1, 16'h8001, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b1, 16'h8003, 1'b1, 3'd2, 8'h01, "pressed0_same_cycle");
    cyc(1'b0, 16'h0, 1'b1, 3'd2, 8'h02, "pressed0_new_edge");
    cyc(1'b1, 16'h8003, 1'b1, 3'd4, 8'h03, "status_same_cycle");
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h01, "status_set_wins");
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h00, "status_after_clear");

    // release edges (only when the optional registers exist)
    cyc(1'b0, 16'h0, 1'b1, 3'd5, REL ? 8'h01 : 8'h00, "released0_prior");
    cyc(1'b1, 16'h80FF, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b1, 16'h800F, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b0, 16'h0, 1'b1, 3'd5, REL ? 8'hF0 : 8'h00, "released0");
    cyc(1'b0, 16'h0, 1'b1, 3'd5, 8'h00, "released0_cleared");
    cyc(1'b0, 16'h0, 1'b1, 3'd6, 8'h00, "released1");

    // unmapped address returns zero and disturbs nothing
    cyc(1'b0, 16'h0, 1'b1, 3'd7, 8'h00, "unmapped");
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 8'h0F, "state0_after_unmapped");

    // asynchronous reset between a capture and its read
    cyc(1'b1, 16'h8001, 1'b0, 3'd0, 8'h00, "");
    #2;
    rst_b = 1'b0;
    #1;
    check("async_reset_out", cpu_data_out, 8'h00);
    @(negedge clk_1);
    rst_b = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 8'h00, "state0_after_reset");
    cyc(1'b0, 16'h0, 1'b1, 3'd4, 8'h00, "status_after_reset");
    cyc(1'b1, 16'h0001, 1'b0, 3'd0, 8'h00, "");
    cyc(1'b0, 16'h0, 1'b1, 3'd2, 8'h01, "pressed0_after_reset");

    // random traffic against the behavioural model, starting from reset
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = '0;
      m_pressed[k] = '0;
      m_released[k] = '0;
    end
    m_fresh = 1'b0;
    m_over  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 4) != 0);
      b  = 16'($urandom);
      a  = 3'($urandom_range(0, 7));
      cyc(v, b, rd, a, model_read(a), "random_read");
      model_update(v, b, rd, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
